// File: rtl/common_pkg.sv
// Definitions shared by every bus master in the core.
//   RESP_ERROR : value of the bus response bit that flags a failed transfer.
package common_pkg;

    localparam logic RESP_ERROR = 1'b1;

endpackage : common_pkg

// File: rtl/fetch_pkg.sv
// Types and constants for the instruction prefetcher.
//   INSTR_BYTES   : fetch PC increment per instruction.
//   fetch_state_t : prefetcher FSM states.
//   fetch_entry_t : default 32-bit queue entry {address, instruction, error}.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        DRAIN   = 2'd2,
        FAULT   = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] instruction;
        logic        error;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched instructions for the decoder.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clear_i        : empty the queue; wins over push_i and pop_i
//   push_i         : write push_entry_i at the tail (ignored when full)
//   pop_i          : drop the head entry (ignored when empty)
//   head_o         : head entry, read straight from registered storage
//   head_valid_o   : queue not empty
//   count_o        : number of stored entries
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  entry_t                     push_entry_i,
    input  logic                       pop_i,
    output entry_t                     head_o,
    output logic                       head_valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign do_push = push_i && !clear_i && (count_q != DEPTH_C);
    assign do_pop  = pop_i && !clear_i && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            // Push and pop together leave the count unchanged.
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count_q says so.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o       = mem_q[rd_ptr_q];
    assign head_valid_o = (count_q != '0);
    assign count_o      = count_q;

endmodule : fetch_queue

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: owns the fetch PC, keeps up to DEPTH fetched
// instructions queued for the decoder, abandons in-flight fetches on a
// redirect and tags bus errors onto the queued instruction.
//   clock, reset        : clock, synchronous active-high reset
//   redirect            : restart fetching at redirect_address, drop queue
//   redirect_address    : new fetch PC (low two bits ignored)
//   bus_available       : bus free for this master
//   bus_ready           : device ready / transfer done
//   bus_response        : response code (RESP_ERROR flags a failure)
//   bus_read_data       : returned instruction word
//   bus_start           : transfer request, held until completion
//   bus_address         : fetch address
//   bus_write           : always 0, this master only reads
//   out_valid/out_ready : decoder handshake; the head entry transfers on
//                         every cycle both are high, and out_* stay stable
//                         while out_valid is high and out_ready is low
//   out_address         : head instruction address
//   out_instruction     : head instruction word
//   out_error           : head fetch returned RESP_ERROR
//   occupancy           : entries currently queued
//   debug_state         : current FSM state (fetch_state_t encoding)
module prefetch_unit #(
    parameter int                ADDR_WIDTH   = 32,
    parameter int                DATA_WIDTH   = 32,
    parameter int                DEPTH        = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [ADDR_WIDTH-1:0]      redirect_address,
    input  logic                       bus_available,
    input  logic                       bus_ready,
    input  logic                       bus_response,
    input  logic [DATA_WIDTH-1:0]      bus_read_data,
    output logic                       bus_start,
    output logic [ADDR_WIDTH-1:0]      bus_address,
    output logic                       bus_write,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_WIDTH-1:0]      out_address,
    output logic [DATA_WIDTH-1:0]      out_instruction,
    output logic                       out_error,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [1:0]                 debug_state
);

    import fetch_pkg::*;
    import common_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]           DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INSTR_BYTES);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0] instruction;
        logic                  error;
    } entry_t;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] bus_address_q, bus_address_d;
    logic                  bus_start_q, bus_start_d;

    logic                  in_flight;
    logic                  complete;
    logic                  credit;
    logic                  resp_is_error;
    logic [CW:0]           committed;
    logic                  q_push;
    logic                  q_pop;
    logic                  q_valid;
    logic [CW-1:0]         q_count;
    entry_t                q_push_entry;
    entry_t                q_head;
    logic                  unused_redirect_lsbs;

    assign in_flight     = (state_q == WAITING) || (state_q == DRAIN);
    // The bus holds bus_ready low in the first WAITING cycle, so the first
    // in-flight cycle with bus_ready high is the completion.
    assign complete      = in_flight && bus_ready;
    assign resp_is_error = (bus_response == RESP_ERROR);

    // Count the in-flight fetch against the queue so a landing response
    // always has a free slot.
    assign committed = {1'b0, q_count} + {{CW{1'b0}}, in_flight};
    assign credit    = (committed < DEPTH_C);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        bus_start_d   = bus_start_q;
        bus_address_d = bus_address_q;
        q_push        = 1'b0;
        if (redirect) begin
            fetch_pc_d = {redirect_address[ADDR_WIDTH-1:2], 2'b00};
            case (state_q)
                WAITING, DRAIN: begin
                    // A transfer still open must finish on the bus before
                    // a new one may start; its data is thrown away.
                    if (complete) begin
                        bus_start_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus_available && bus_ready && credit) begin
                        bus_start_d   = 1'b1;
                        bus_address_d = fetch_pc_q;
                        fetch_pc_d    = fetch_pc_q + PC_STEP;
                        state_d       = WAITING;
                    end
                end
                WAITING: begin
                    if (complete) begin
                        bus_start_d = 1'b0;
                        q_push      = 1'b1;
                        state_d     = resp_is_error ? FAULT : IDLE;
                    end
                end
                DRAIN: begin
                    if (complete) begin
                        bus_start_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                // FAULT: fetching stops until the control unit redirects.
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_VECTOR;
            bus_start_q   <= 1'b0;
            bus_address_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            bus_start_q   <= bus_start_d;
            bus_address_q <= bus_address_d;
        end
    end

    assign q_push_entry = '{address:     bus_address_q,
                            instruction: bus_read_data,
                            error:       resp_is_error};
    // A pop coinciding with a redirect still reaches the decoder; the
    // clear then empties whatever is left.
    assign q_pop = q_valid && out_ready;

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fetch_queue (
        .clk_i        (clock),
        .rst_i        (reset),
        .clear_i      (redirect),
        .push_i       (q_push),
        .push_entry_i (q_push_entry),
        .pop_i        (q_pop),
        .head_o       (q_head),
        .head_valid_o (q_valid),
        .count_o      (q_count)
    );

    assign bus_start            = bus_start_q;
    assign bus_address          = bus_address_q;
    assign bus_write            = 1'b0;
    assign out_valid            = q_valid;
    assign out_address          = q_head.address;
    assign out_instruction      = q_head.instruction;
    assign out_error            = q_valid && q_head.error;
    assign occupancy            = q_count;
    assign debug_state          = state_q;
    assign unused_redirect_lsbs = ^redirect_address[1:0];

endmodule : prefetch_unit

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit (DEPTH=4, RESET_VECTOR=0x100).
module tb_prefetch_unit;

    import fetch_pkg::*;

    localparam logic [31:0] RV = 32'h100;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    always #5 clock = ~clock;

    logic        redirect = 1'b0;
    logic [31:0] redirect_address = '0;
    logic        bus_available = 1'b0;
    logic        bus_ready = 1'b1;
    logic        bus_response = 1'b0;
    logic [31:0] bus_read_data = '0;
    logic        bus_start;
    logic [31:0] bus_address;
    logic        bus_write;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_address;
    logic [31:0] out_instruction;
    logic        out_error;
    logic [2:0]  occupancy;
    logic [1:0]  debug_state;

    prefetch_unit #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .DEPTH        (4),
        .RESET_VECTOR (RV)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .redirect         (redirect),
        .redirect_address (redirect_address),
        .bus_available    (bus_available),
        .bus_ready        (bus_ready),
        .bus_response     (bus_response),
        .bus_read_data    (bus_read_data),
        .bus_start        (bus_start),
        .bus_address      (bus_address),
        .bus_write        (bus_write),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_address      (out_address),
        .out_instruction  (out_instruction),
        .out_error        (out_error),
        .occupancy        (occupancy),
        .debug_state      (debug_state)
    );

    // ---------------- scoreboard state ----------------
    logic [64:0] exp_q[$];          // {address, instruction, error}
    int          n_checks  = 0;
    int          n_pass    = 0;
    int          issue_cnt = 0;
    int          wait_cnt  = 0;
    int          base      = 0;
    logic        last_start = 1'b0;
    logic        err_en    = 1'b0;
    logic [31:0] err_addr  = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- bus responder ----------------
    // Ready is low in the first cycle of a transfer and high in the second.
    always @(negedge clock) begin
        if (!bus_start) begin
            wait_cnt  = 0;
            bus_ready = 1'b1;
        end else begin
            wait_cnt++;
            bus_ready = (wait_cnt >= 2);
        end
        bus_read_data = mem_word(bus_address);
        bus_response  = err_en && (bus_address == err_addr);
    end

    // Count every new transfer request.
    always @(negedge clock) begin
        if (bus_start && !last_start) issue_cnt++;
        last_start = bus_start;
    end

    // Decoder-side monitor: every accepted head must match the next expectation.
    always @(negedge clock) begin
        logic [64:0] e;
        #2;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_head", 64'(out_address), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("head_address", 64'(out_address), 64'(e[64:33]));
                check("head_instr", 64'(out_instruction), 64'(e[32:1]));
                check("head_error", 64'(out_error), 64'(e[0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic expect_entry(input logic [31:0] a, input logic err);
        exp_q.push_back({a, mem_word(a), err});
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        redirect = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_issues(input int target, input string tag);
        for (int i = 0; i < 100 && issue_cnt < target; i++) step();
        check(tag, 64'(issue_cnt), 64'(target));
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
        check(tag, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bus_start"}, 64'(bus_start), 64'(0));
        check({tag, "_bus_address"}, 64'(bus_address), 64'(0));
        check({tag, "_bus_write"}, 64'(bus_write), 64'(0));
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_out_error"}, 64'(out_error), 64'(0));
        check({tag, "_occupancy"}, 64'(occupancy), 64'(0));
        check({tag, "_state"}, 64'(debug_state), 64'(IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        // T1: reset values, then streaming fetch 0x100, 0x104, 0x108.
        bus_available = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        check_reset_outputs("t1_reset");
        expect_entry(32'h100, 1'b0);
        expect_entry(32'h104, 1'b0);
        expect_entry(32'h108, 1'b0);
        base = issue_cnt;
        reset = 1'b0;
        wait_issues(base + 1, "t1_issue0");
        check("t1_addr0", 64'(bus_address), 64'h100);
        wait_issues(base + 3, "t1_issue2");
        check("t1_addr2", 64'(bus_address), 64'h108);
        check("t1_bus_write", 64'(bus_write), 64'(0));
        bus_available = 1'b0;
        wait_drain("t1_drain");

        // T2: decoder stalled, queue fills to DEPTH, then resumes at 0x110.
        out_ready = 1'b0;
        bus_available = 1'b1;
        base = issue_cnt;
        apply_reset();
        repeat (30) step();
        check("t2_head_addr_a", 64'(out_address), 64'h100);
        repeat (10) step();
        check("t2_issues", 64'(issue_cnt - base), 64'(4));
        check("t2_occupancy", 64'(occupancy), 64'(4));
        check("t2_bus_start", 64'(bus_start), 64'(0));
        check("t2_head_valid", 64'(out_valid), 64'(1));
        check("t2_head_addr_b", 64'(out_address), 64'h100);
        check("t2_head_instr", 64'(out_instruction), 64'(mem_word(32'h100)));
        for (int a = 'h100; a <= 'h110; a += 4) expect_entry(32'(a), 1'b0);
        out_ready = 1'b1;
        wait_issues(base + 5, "t2_resume");
        check("t2_resume_addr", 64'(bus_address), 64'h110);
        bus_available = 1'b0;
        wait_drain("t2_drain");

        // T3: redirect to 0x2002 while waiting on 0x104.
        bus_available = 1'b1;
        base = issue_cnt;
        apply_reset();
        expect_entry(32'h100, 1'b0);
        wait_issues(base + 2, "t3_issue1");
        check("t3_wait_addr", 64'(bus_address), 64'h104);
        expect_entry(32'h2000, 1'b0);
        redirect = 1'b1;
        redirect_address = 32'h2002;
        step();
        redirect = 1'b0;
        check("t3_out_valid", 64'(out_valid), 64'(0));
        check("t3_state_drain", 64'(debug_state), 64'(DRAIN));
        check("t3_bus_held", 64'(bus_start), 64'(1));
        wait_issues(base + 3, "t3_new_issue");
        check("t3_new_addr", 64'(bus_address), 64'h2000);
        bus_available = 1'b0;
        wait_drain("t3_drain");

        // T4: error on 0x108 parks the FSM in FAULT until a redirect.
        err_addr = 32'h108;
        err_en = 1'b1;
        bus_available = 1'b1;
        base = issue_cnt;
        apply_reset();
        expect_entry(32'h100, 1'b0);
        expect_entry(32'h104, 1'b0);
        expect_entry(32'h108, 1'b1);
        wait_drain("t4_drain_err");
        repeat (10) step();
        check("t4_issues", 64'(issue_cnt - base), 64'(3));
        check("t4_bus_start", 64'(bus_start), 64'(0));
        check("t4_state_fault", 64'(debug_state), 64'(FAULT));
        err_en = 1'b0;
        expect_entry(32'h300, 1'b0);
        redirect = 1'b1;
        redirect_address = 32'h300;
        step();
        redirect = 1'b0;
        check("t4_state_idle", 64'(debug_state), 64'(IDLE));
        wait_issues(base + 4, "t4_refetch");
        check("t4_refetch_addr", 64'(bus_address), 64'h300);
        bus_available = 1'b0;
        wait_drain("t4_drain_ok");

        // T5: redirect coinciding with a completion and a pop.
        out_ready = 1'b0;
        bus_available = 1'b1;
        base = issue_cnt;
        apply_reset();
        expect_entry(32'h100, 1'b0);
        wait_issues(base + 2, "t5_issue1");
        check("t5_wait_addr", 64'(bus_address), 64'h104);
        step();   // completion cycle for 0x104
        check("t5_occ_before", 64'(occupancy), 64'(1));
        redirect = 1'b1;
        redirect_address = 32'h400;
        out_ready = 1'b1;
        step();
        redirect = 1'b0;
        check("t5_occ_after", 64'(occupancy), 64'(0));
        check("t5_out_valid", 64'(out_valid), 64'(0));
        check("t5_state_idle", 64'(debug_state), 64'(IDLE));
        check("t5_bus_start", 64'(bus_start), 64'(0));
        check("t5_popped", 64'(exp_q.size()), 64'(0));

        // T6: reset asserted while waiting on 0x400.
        wait_issues(base + 3, "t6_issue");
        check("t6_wait_addr", 64'(bus_address), 64'h400);
        reset = 1'b1;
        step();
        check_reset_outputs("t6_reset");
        expect_entry(32'h100, 1'b0);
        reset = 1'b0;
        wait_issues(base + 4, "t6_restart");
        check("t6_restart_addr", 64'(bus_address), 64'h100);
        bus_available = 1'b0;
        wait_drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_prefetch_unit

// File: doc/prefetch_unit.md
# prefetch_unit

Parametrised instruction prefetcher between the bus master and the decoder skid buffer. It owns the fetch PC and fetches ahead into a DEPTH-entry instruction queue, so decode is not stalled on every bus round trip. It takes redirects (branch/trap/flush) from the control unit, safely drains any bus transfer in flight, and tags bus errors onto the queued instruction instead of dropping them.

## Interface
Parameters:
- ADDR_WIDTH, 32, fetch address width.
- DATA_WIDTH, 32, instruction word width.
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_VECTOR, 0, fetch PC after reset.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- redirect  in  1  control unit: discard queue and in-flight fetch, restart at redirect_address.
- redirect_address  in  ADDR_WIDTH  new fetch PC; bits [1:0] forced to 0.
- bus_available  in  1  no other transaction owns the bus.
- bus_ready  in  1  device ready / transfer complete.
- bus_response  in  1  RESP_ERROR when set.
- bus_read_data  in  DATA_WIDTH  returned instruction word.
- bus_start  out  1  transfer request, held until completion.
- bus_address  out  ADDR_WIDTH  fetch address.
- bus_write  out  1  constant 0.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decoder accepts head.
- out_address  out  ADDR_WIDTH  head instruction address.
- out_instruction  out  DATA_WIDTH  head instruction word.
- out_error  out  1  head fetch returned RESP_ERROR.
- occupancy  out  $clog2(DEPTH+1)  entries in queue.

## Operation
- Reset values: bus_start=0, bus_address=0, bus_write=0, out_valid=0, out_error=0, occupancy=0, fetch_pc=RESET_VECTOR, state=IDLE.
- Credit: issue only if occupancy + (transfer in flight) < DEPTH; queue can never overflow.
- IDLE: if !redirect && bus_available && bus_ready && credit → bus_start=1, bus_address=fetch_pc, fetch_pc+=4 (wraps mod 2^ADDR_WIDTH), → WAITING.
- WAITING: completion is the first WAITING cycle with bus_ready=1 (bus contract: bus_ready low in the first WAITING cycle). On completion bus_start=0; push {bus_address, bus_read_data, error=(bus_response==RESP_ERROR)}; → FAULT if error, else IDLE.
- FAULT: no issues; queue still drains; leave only via redirect.
- DRAIN: an in-flight transfer is being abandoned. On completion bus_start=0, data discarded (error ignored), → IDLE.
- Redirect (any state, highest priority): queue cleared; fetch_pc=redirect_address; no issue that cycle. IDLE/FAULT/DRAIN → IDLE (DRAIN stays DRAIN if still incomplete); WAITING → DRAIN, or → IDLE if completion in the same cycle (response discarded).
- Pop: out_valid && out_ready removes head. Simultaneous push and pop both occur; occupancy unchanged.
- Redirect with pop in the same cycle: the pop is consumed by the decoder but the queue is still fully cleared.

## Timing
- Issue decision in cycle N → bus_start/bus_address visible N+1.
- Completion at cycle C → out_valid at C+1 if queue was empty (no combinational bypass).
- Redirect at cycle R: out_valid=0 at R+1. Earliest new bus_start at R+2 (from IDLE), or one cycle after drain completion.
- Minimum issue interval: 2 cycles plus bus latency (WAITING→IDLE→issue).
- out_* are driven from registered queue storage. Outputs hold stable while out_valid && !out_ready.

## Structure
- Package fetch_pkg: fetch_entry_t {address, instruction, error}; fetch_state_t {IDLE, WAITING, DRAIN, FAULT}; INSTR_BYTES=4. RESP_ERROR stays in the common package.
- Sub-module fetch_queue: synchronous FIFO (DEPTH, entry type), with push, pop, clear, count, and head outputs. Clear has priority over push and pop.
- Top level: FSM, fetch_pc, credit logic, bus drive.

## Test plan
- Reset, RESET_VECTOR=0x100, zero-latency OK bus, out_ready=1 → out_address sequence 0x100,0x104,0x108 with matching instructions; bus_write always 0.
- out_ready=0, DEPTH=4 → exactly 4 fetches issued (occupancy=4), bus_start stays 0. Raise out_ready → fetching resumes at 0x110.
- Redirect to 0x2002 while WAITING on 0x104 → response for 0x104 discarded. Next fetch address is 0x2000; no stale entry ever on out_*.
- RESP_ERROR on 0x108 → entry at 0x108 with out_error=1; no further bus_start until redirect to 0x300; then fetch 0x300 with out_error=0.
- Redirect in the same cycle as completion and a pop → queue empty next cycle, state IDLE, no DRAIN.
- Reset asserted mid-WAITING → next cycle all outputs at reset values and fetch_pc=RESET_VECTOR.
